// File: rtl/fifo_flagged_if.sv
// Handshake and status bundle for fifo_flagged: the producer/consumer side drives
// data and requests, and the FIFO returns its head word and occupancy flags.
interface fifo_flagged_if #(
    parameter int FIFO_width = 64,
    parameter int CW         = 4
);
    logic [FIFO_width-1:0] in;
    logic                  produce;
    logic                  consume;
    logic                  flush;
    logic [FIFO_width-1:0] out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         util;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output in, produce, consume, flush,
        input  out, full, empty, almost_full, almost_empty, util, overflow, underflow
    );

    modport slave (
        input  in, produce, consume, flush,
        output out, full, empty, almost_full, almost_empty, util, overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with occupancy flags and sticky
// overflow/underflow errors; any depth >= 2, every entry usable.
module fifo_flagged #(
    parameter int FIFO_depth = 8,
    parameter int FIFO_width = 64,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 1,
    localparam int CW = $clog2(FIFO_depth + 1),
    localparam int PW = $clog2(FIFO_depth)
) (
    input logic           clk,
    input logic           rst,
    fifo_flagged_if.slave bus
);

    logic [FIFO_width-1:0] mem [FIFO_depth];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         util;
    logic                  overflow;
    logic                  underflow;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic ovf_set;
    logic unf_set;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags decode straight from the registered count so none of them lags util.
    assign full  = (util == CW'(FIFO_depth));
    assign empty = (util == '0);

    // A full FIFO still takes a write when the head is consumed in the same cycle;
    // an empty FIFO never bypasses, so the read side is gated by empty alone.
    assign wr_en   = bus.produce && (!full || bus.consume);
    assign rd_en   = bus.consume && !empty;
    assign ovf_set = bus.produce && full && !bus.consume;
    assign unf_set = bus.consume && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            util      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            util      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_en && !rd_en)      util <= util + 1'b1;
            else if (rd_en && !wr_en) util <= util - 1'b1;
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset/flush; only the pointers matter.
    always_ff @(posedge clk) begin
        if (wr_en && !bus.flush && !rst) mem[wr_ptr] <= bus.in;
    end

    assign bus.out          = empty ? '0 : mem[rd_ptr];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (util >= CW'(AFULL_TH));
    assign bus.almost_empty = (util <= CW'(AEMPTY_TH));
    assign bus.util         = util;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged (depth 5, width 8, thresholds 4/1) against
// a queue-based reference model.
module tb_fifo_flagged;

    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    fifo_flagged_if #(.FIFO_width(8), .CW(3)) bus ();

    fifo_flagged #(
        .FIFO_depth(DEPTH),
        .FIFO_width(8),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_unf;
    int         n_cmp;
    int         n_err;

    // {out, util, full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [16:0] exp_vec();
        int sz;
        logic [7:0] hd;
        sz = q.size();
        hd = (sz > 0) ? q[0] : 8'h00;
        return {hd, 3'(sz), (sz == DEPTH), (sz == 0), (sz >= AF), (sz <= AE), m_ovf, m_unf};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {bus.out, bus.util, bus.full, bus.empty, bus.almost_full,
                bus.almost_empty, bus.overflow, bus.underflow};
    endfunction

    // Drive one cycle, advance the model from the pre-edge state, settle 1ns after the edge.
    task automatic step(input logic prod, input logic cons, input logic fl, input logic [7:0] d);
        bit wr;
        bit rd;
        bus.produce = prod;
        bus.consume = cons;
        bus.flush   = fl;
        bus.in      = d;
        wr = prod && (q.size() < DEPTH || cons);
        rd = cons && (q.size() > 0);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (prod && q.size() == DEPTH && !cons) m_ovf = 1'b1;
            if (cons && q.size() == 0) m_unf = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.produce = 1'b0;
        bus.consume = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.produce = 1'b0;
        bus.consume = 1'b0;
        bus.flush   = 1'b0;
        bus.in      = 8'h00;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(), {8'h00, 3'd0, 6'b010100});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i * 8'h11));
            n_cmp++;
            if (obs_vec() !== exp_vec() || bus.util !== 3'(i) || bus.out !== 8'h11) begin
                n_err++;
                $display("FAIL fill_%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 1'b0, 8'h66);
        n_cmp++;
        if (bus.util !== 3'd5 || bus.overflow !== 1'b1 || bus.out !== 8'h11) begin
            n_err++;
            $display("FAIL overflow got util=%0d ovf=%b out=%h want util=5 ovf=1 out=11",
                     bus.util, bus.overflow, bus.out);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] want[5];
        want = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
        step(1'b1, 1'b1, 1'b0, 8'h77);
        n_cmp++;
        if (bus.util !== 3'd5 || bus.out !== 8'h22 || bus.full !== 1'b1) begin
            n_err++;
            $display("FAIL full_rw got util=%0d out=%h want util=5 out=22", bus.util, bus.out);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.out !== want[i]) begin
                n_err++;
                $display("FAIL read_order_%0d got=%h want=%h", i, bus.out, want[i]);
            end
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL drained got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.util !== 3'd0 || bus.underflow !== 1'b1 || bus.out !== 8'h00) begin
            n_err++;
            $display("FAIL underflow got util=%0d unf=%b out=%h want 0/1/00",
                     bus.util, bus.underflow, bus.out);
        end
        step(1'b1, 1'b1, 1'b0, 8'h99);
        n_cmp++;
        if (bus.util !== 3'd1 || bus.out !== 8'h99 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL no_bypass got util=%0d out=%h want util=1 out=99", bus.util, bus.out);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b0, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 1'b0, 8'hA2);
        n_cmp++;
        if (bus.util !== 3'd3) begin
            n_err++;
            $display("FAIL pre_flush got util=%0d want 3", bus.util);
        end
        step(1'b1, 1'b0, 1'b1, 8'hA3);
        n_cmp++;
        if (obs_vec() !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL flush got=%h want=%h", obs_vec(), {8'h00, 3'd0, 6'b010100});
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        n_cmp++;
        if (obs_vec() !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got=%h want=%h", obs_vec(), {8'h00, 3'd0, 6'b010100});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit p;
        bit c;
        bit f;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            c = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 3);
            step(p, c, f, 8'($urandom));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/fifo_flagged.md
FIFO_FLAGGED -- requirements
Module: fifo_flagged

Interface
REQ-001 Parameter FIFO_depth, default 8, meaning: number of storage entries; legal range >= 2, not limited to powers of two.
REQ-002 Parameter FIFO_width, default 64, meaning: data bits per entry.
REQ-003 Parameter AFULL_TH, default 6, meaning: almost_full threshold; legal range 1..FIFO_depth.
REQ-004 Parameter AEMPTY_TH, default 1, meaning: almost_empty threshold; legal range 0..FIFO_depth-1.
REQ-005 Port clk, input, 1, meaning: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, meaning: asynchronous, active-high reset.
REQ-007 Port in, input, FIFO_width, meaning: write data.
REQ-008 Port produce, input, 1, meaning: write request.
REQ-009 Port consume, input, 1, meaning: read request; acknowledges the word currently on out.
REQ-010 Port flush, input, 1, meaning: synchronous clear of the queue and error flags.
REQ-011 Port out, output, FIFO_width, meaning: head word (first-word-fall-through).
REQ-012 Port full / empty, output, 1 each, meaning: count==FIFO_depth / count==0.
REQ-013 Port almost_full / almost_empty, output, 1 each, meaning: count>=AFULL_TH / count<=AEMPTY_TH.
REQ-014 Port util, output, CW=$clog2(FIFO_depth+1), meaning: current occupancy, 0..FIFO_depth.
REQ-015 Port overflow / underflow, output, 1 each, meaning: sticky error flags.

Function
REQ-016 The FIFO SHALL hold exactly FIFO_depth words; all FIFO_depth entries are usable.
REQ-017 Head and tail pointers SHALL wrap from FIFO_depth-1 to 0.
REQ-018 out SHALL equal the head entry when not empty and all-zeros when empty, combinationally from registered state; zero read latency.
REQ-019 A write SHALL be accepted when produce=1 and (full=0 or consume=1 with full=1).
REQ-020 A read SHALL be accepted when consume=1 and empty=0.
REQ-021 Write when empty with consume=1: only the write is accepted; no bypass; the new word appears on out the next cycle.
REQ-022 Simultaneous accepted read and write SHALL leave util unchanged and advance both pointers, including when full.
REQ-023 util SHALL be +1 on write-only, -1 on read-only, and unchanged otherwise; it never exceeds FIFO_depth and never goes below 0.
REQ-024 produce=1 with full=1 and consume=0 SHALL drop the data, leave state unchanged, and set overflow the next cycle.
REQ-025 consume=1 with empty=1 SHALL leave state unchanged and set underflow the next cycle.
REQ-026 overflow and underflow SHALL remain set until rst or flush.
REQ-027 All flag outputs SHALL be combinational decodes of registered util; no flag lags util.
REQ-028 flush=1 SHALL on that edge zero the pointers, util, overflow and underflow, taking priority over produce and consume in the same cycle; storage contents are not cleared.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force the pointers, util, overflow and underflow to 0.
REQ-030 While and after rst: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0, never true), out=0.
REQ-031 Assertion of rst mid-operation SHALL discard all queued data; storage memory is not reset.

Verification (FIFO_depth=5, FIFO_width=8, AFULL_TH=4, AEMPTY_TH=1)
REQ-032 Fill: write 0x11..0x55 -> util 1..5; almost_empty drops at util=2; almost_full rises at util=4; full at 5; out=0x11 throughout.
REQ-033 Overflow: full, produce=1, consume=0, in=0x66 -> util stays 5, overflow=1 next cycle, later reads yield 0x11..0x55 only.
REQ-034 Full with read+write: in=0x77 -> util stays 5, out=0x22 next cycle; after 5 reads the read order is 0x22,0x33,0x44,0x55,0x77 (wrap exercised).
REQ-035 Underflow: empty, consume=1 -> util 0, underflow=1, out=0; empty with produce=consume=1, in=0x99 -> util=1, out=0x99 next cycle.
REQ-036 Flush with produce=1 at util=3 -> util=0, empty=1, error flags cleared; rst asserted mid-cycle -> outputs reach reset values before the next clk edge.
